axis_pktgen: RTL and testbench
==============================

# axis_pktgen

AXI-Stream packet transmitter: on command, emits one or more packets of a programmed beat count carrying an incrementing data pattern, with TLAST on the final beat of each packet. It is the source end of the stream interface. It drives the stream-side inputs of downstream register stages, packet checkers and FIFOs, and serves as a bench and bring-up traffic source. It honours full AXI-Stream backpressure and runs at one beat per clock when the sink is always ready.

## Interface
- DW, 16: TDATA width in bits.
- LW, 8: width of the packet-length field.
- GW, 8: width of the inter-packet gap field.

Ports:
- S_AXI_ACLK  in  1  single clock; all logic is on the rising edge.
- S_AXI_ARESET  in  1  reset, synchronous and active-high.
- i_start  in  1  start command; acted on only in IDLE.
- i_stop  in  1  ends repeat mode; the current packet still completes.
- i_len  in  LW  beats per packet; 0 means the start is ignored.
- i_seed  in  DW  TDATA value of the first beat.
- i_repeat  in  1  when set with start, packets repeat until stopped.
- i_gap  in  GW  idle cycles between repeated packets.
- M_AXIS_TVALID  out  1  beat valid.
- M_AXIS_TREADY  in  1  sink ready.
- M_AXIS_TDATA  out  DW  beat data.
- M_AXIS_TLAST  out  1  final beat of the packet.
- o_busy  out  1  high whenever the state is not IDLE.
- o_pkt_count  out  16  count of completed packets; wraps at 2^16.

## Operation
- **Latching at start.** i_len, i_seed, i_repeat and i_gap are latched when a start is accepted. Later changes have no effect until the next start.
- **Registers.** All outputs are registered. A beat counter counts the beats remaining, and a gap counter counts the idle cycles remaining.
- **State IDLE.** TVALID=0.
  - i_start && i_len!=0: load TDATA=i_seed, TLAST=(i_len==1), TVALID=1, beats remaining=i_len, then go to SEND.
  - i_start && i_len==0: no effect.
- **State SEND.** TVALID=1. A beat transfers when TVALID && TREADY.
  - Hold rule: while TVALID && !TREADY, TDATA and TLAST stay stable and TVALID stays 1.
  - Non-last transfer: TDATA<=TDATA+1 (modulo 2^DW), beats remaining decrements, and TLAST<=(beats remaining after the decrement == 1).
  - Last transfer (TLAST=1): o_pkt_count increments, then:
    - If repeat is latched and gap==0: go straight to the next packet. TVALID stays 1, TDATA<=TDATA+1, and the beat counter and TLAST reload from the latched length.
    - If repeat is latched and gap>0: TVALID<=0, gap counter<=latched gap, go to GAP.
    - Otherwise: TVALID<=0 and go to IDLE.
- **State GAP.** TVALID=0. The gap counter decrements each cycle. In the cycle it reads 1, the next packet is loaded: TVALID<=1, TDATA continues at last beat+1, and length and TLAST reload. Then go to SEND.
- **i_stop.** In any state it clears latched repeat.
  - In GAP, it returns the block to IDLE on the next edge with TVALID=0.
  - In SEND, the current packet finishes normally, then the block goes to IDLE.
- **i_start while busy.** Ignored. It does not relatch any field.
- **Data across packets.** TDATA continues incrementing from packet to packet; the seed applies only to the first beat after a start.

## Timing
- **Reset values.** On reset (synchronous, high at the edge): state IDLE, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, o_busy=0, o_pkt_count=0, latched repeat=0.
- **Reset mid-packet.** TVALID drops at the reset edge, the packet is abandoned without TLAST, and no count is taken.
- **Start latency.** i_start is sampled at edge N; TVALID=1 with the first beat is visible after edge N, during cycle N+1.
- **Throughput.** With TREADY held high, a packet of L beats occupies L consecutive cycles.
- **Repeat spacing.** gap=0 gives back-to-back packets with no idle cycle. gap=G gives exactly G cycles of TVALID=0 between a TLAST transfer and the next first beat.
- **o_busy.** Rises with TVALID after an accepted start and falls on the edge that leaves SEND or GAP for IDLE.
- **o_pkt_count.** Updates on the edge that transfers the TLAST beat.
- **TREADY independence.** TVALID never depends combinationally on TREADY. TREADY may toggle arbitrarily.

## Test plan
- **Single packet.** len=4, seed=0x1000, TREADY=1 -> four consecutive beats 0x1000..0x1003, TLAST only on 0x1003, o_pkt_count=1, o_busy low one cycle after the last beat.
- **Backpressure.** len=3, TREADY toggling 1,0,0,1,0,1 -> beats 0x0..0x2 each held stable while stalled, TLAST on the third transfer only, no beat lost or duplicated.
- **Repeat with gap.** len=2, seed=0xA0, repeat=1, gap=2, then i_stop during the third packet -> beats A0,A1 (last), 2 idle cycles, A2,A3, 2 idle cycles, A4,A5, then IDLE; o_pkt_count=3.
- **Back-to-back, wrap-around and zero length.** len=3, seed=0xFFFE, repeat=1, gap=0 -> FFFE, FFFF, 0000(last), 0001… with TVALID continuously high. Separately, a start with len=0 leaves TVALID=0 and o_busy=0.
- **Start while busy.** i_start with len=1 and seed=0x55 pulsed during a len=5 packet -> the packet completes unchanged, and no extra packet is emitted afterwards.
- **Reset mid-packet.** S_AXI_ARESET asserted on the third beat of a len=6 packet -> TVALID=0 from the next cycle and o_pkt_count=0. A following start with seed=0x10 begins cleanly at 0x10.

Source files
------------

// File: rtl/axis_pktgen.sv
// AXI-Stream packet generator. It emits packets of a programmed length that
// carry an incrementing data pattern, with TLAST on the final beat of each
// packet. Repeat mode can add an optional idle gap between packets.
module axis_pktgen #(
  parameter int DW = 16,
  parameter int LW = 8,
  parameter int GW = 8
) (
  input  logic          S_AXI_ACLK,
  input  logic          S_AXI_ARESET,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic [LW-1:0] i_len,
  input  logic [DW-1:0] i_seed,
  input  logic          i_repeat,
  input  logic [GW-1:0] i_gap,
  output logic          M_AXIS_TVALID,
  input  logic          M_AXIS_TREADY,
  output logic [DW-1:0] M_AXIS_TDATA,
  output logic          M_AXIS_TLAST,
  output logic          o_busy,
  output logic [15:0]   o_pkt_count
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t        state_reg;
  logic [LW-1:0] len_reg;
  logic [LW-1:0] beats_reg;
  logic [GW-1:0] gap_reg;
  logic [GW-1:0] gap_cnt_reg;
  logic          repeat_reg;
  logic          tvalid_reg;
  logic          tlast_reg;
  logic [DW-1:0] tdata_reg;
  logic          busy_reg;
  logic [15:0]   pkt_count_reg;

  // i_stop takes effect in the same cycle as the TLAST transfer, so the
  // packet that is ending does not start another one.
  logic repeat_eff;
  assign repeat_eff = repeat_reg & ~i_stop;

  // Control FSM. Every output comes straight from a register, so TVALID
  // never depends combinationally on TREADY.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      beats_reg     <= '0;
      gap_reg       <= '0;
      gap_cnt_reg   <= '0;
      repeat_reg    <= 1'b0;
      tvalid_reg    <= 1'b0;
      tlast_reg     <= 1'b0;
      tdata_reg     <= '0;
      busy_reg      <= 1'b0;
      pkt_count_reg <= '0;
    end else begin
      if (i_stop) repeat_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          tvalid_reg <= 1'b0;
          if (i_start && (i_len != '0)) begin
            len_reg    <= i_len;
            gap_reg    <= i_gap;
            repeat_reg <= i_repeat & ~i_stop;
            tdata_reg  <= i_seed;
            tlast_reg  <= (i_len == LW'(1));
            beats_reg  <= i_len;
            tvalid_reg <= 1'b1;
            busy_reg   <= 1'b1;
            state_reg  <= SEND;
          end
        end
        SEND: begin
          if (M_AXIS_TREADY) begin
            if (!tlast_reg) begin
              tdata_reg <= tdata_reg + 1'b1;
              beats_reg <= beats_reg - 1'b1;
              tlast_reg <= (beats_reg == LW'(2));
            end else begin
              pkt_count_reg <= pkt_count_reg + 16'd1;
              if (repeat_eff && (gap_reg == '0)) begin
                // Back-to-back: the first beat of the next packet follows
                // immediately.
                tdata_reg <= tdata_reg + 1'b1;
                beats_reg <= len_reg;
                tlast_reg <= (len_reg == LW'(1));
              end else if (repeat_eff) begin
                tvalid_reg  <= 1'b0;
                gap_cnt_reg <= gap_reg;
                state_reg   <= GAP;
              end else begin
                tvalid_reg <= 1'b0;
                busy_reg   <= 1'b0;
                state_reg  <= IDLE;
              end
            end
          end
        end
        GAP: begin
          if (i_stop) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (gap_cnt_reg == GW'(1)) begin
            tvalid_reg <= 1'b1;
            tdata_reg  <= tdata_reg + 1'b1;
            beats_reg  <= len_reg;
            tlast_reg  <= (len_reg == LW'(1));
            state_reg  <= SEND;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 1'b1;
          end
        end
        default: begin
          tvalid_reg <= 1'b0;
          busy_reg   <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

  assign M_AXIS_TVALID = tvalid_reg;
  assign M_AXIS_TDATA  = tdata_reg;
  assign M_AXIS_TLAST  = tlast_reg;
  assign o_busy        = busy_reg;
  assign o_pkt_count   = pkt_count_reg;

endmodule

// File: tb/tb_axis_pktgen.sv
// Testbench for axis_pktgen. Expected beats are queued when a command is
// issued and are popped by a stream monitor each time a beat transfers.
module tb_axis_pktgen;

  logic        clk = 1'b0;
  logic        srst;
  logic        i_start, i_stop, i_repeat;
  logic [7:0]  i_len, i_gap;
  logic [15:0] i_seed;
  logic        tvalid, tready, tlast;
  logic [15:0] tdata;
  logic        busy;
  logic [15:0] pkt_count;

  axis_pktgen #(.DW(16), .LW(8), .GW(8)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (srst),
    .i_start       (i_start),
    .i_stop        (i_stop),
    .i_len         (i_len),
    .i_seed        (i_seed),
    .i_repeat      (i_repeat),
    .i_gap         (i_gap),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TREADY (tready),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TLAST  (tlast),
    .o_busy        (busy),
    .o_pkt_count   (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        last;
    int          gap;   // expected idle cycles before this beat, -1 = unchecked
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Queue the expected beats for npkts packets. With chk_gap clear, the
  // spacing between beats is not checked (used under backpressure).
  task automatic push_pkts(input logic [15:0] seed, input int len, input int npkts,
                           input int gap, input bit chk_gap);
    beat_t b;
    logic [15:0] d;
    d = seed;
    for (int p = 0; p < npkts; p++) begin
      for (int k = 0; k < len; k++) begin
        b.data = d;
        b.last = (k == len - 1);
        if (!chk_gap || (p == 0 && k == 0)) b.gap = -1;
        else if (k == 0) b.gap = gap;
        else b.gap = 0;
        exp_q.push_back(b);
        d = d + 16'd1;
      end
    end
  endtask

  // Called just after a rising edge: pulse i_start for one edge, then
  // scramble the inputs to show that they were latched.
  task automatic do_start(input logic [7:0] len, input logic [15:0] seed,
                          input logic rep, input logic [7:0] gap);
    i_len = len; i_seed = seed; i_repeat = rep; i_gap = gap; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0; i_len = 8'd7; i_seed = 16'hBEEF; i_repeat = 1'b0; i_gap = 8'd9;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check_val({tag, "_timeout"}, exp_q.size(), 0);
  endtask

  task automatic wait_data(input logic [15:0] d, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tvalid && tdata == d) && n < 100);
    check_val({tag, "_seen"}, {16'd0, tdata}, {16'd0, d});
  endtask

  // Stream monitor: samples on the falling edge, pops one expected beat per
  // transfer and checks the hold rule while stalled.
  initial begin : monitor
    beat_t       e;
    int          idle_cnt;
    bit          stall_prev;
    logic [15:0] stall_data;
    logic        stall_last;
    idle_cnt = 0;
    stall_prev = 1'b0;
    stall_data = '0;
    stall_last = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && !srst) begin
        if (stall_prev) begin
          check_val("hold_valid", {31'd0, tvalid}, 32'd1);
          check_val("hold_data", {16'd0, tdata}, {16'd0, stall_data});
          check_val("hold_last", {31'd0, tlast}, {31'd0, stall_last});
        end
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            check_val("extra_beat", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check_val("beat_data", {16'd0, tdata}, {16'd0, e.data});
            check_val("beat_last", {31'd0, tlast}, {31'd0, e.last});
            if (e.gap >= 0) check_val("beat_gap", idle_cnt, e.gap);
          end
          idle_cnt = 0;
        end else begin
          idle_cnt++;
        end
        stall_prev = tvalid && !tready;
        stall_data = tdata;
        stall_last = tlast;
      end else begin
        stall_prev = 1'b0;
        idle_cnt = 0;
      end
    end
  end

  initial begin : stim
    bit pat[6];
    srst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_repeat = 1'b0;
    i_len = '0; i_gap = '0; i_seed = '0; tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    check_val("rst_tvalid", {31'd0, tvalid}, 32'd0);
    check_val("rst_tlast", {31'd0, tlast}, 32'd0);
    check_val("rst_tdata", {16'd0, tdata}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_count", {16'd0, pkt_count}, 32'd0);
    mon_en = 1'b1;

    // Single packet: first beat is visible in the cycle after the start edge.
    @(posedge clk); #1;
    push_pkts(16'h1000, 4, 1, 0, 1'b1);
    do_start(8'd4, 16'h1000, 1'b0, 8'd0);
    @(negedge clk);
    check_val("start_latency_valid", {31'd0, tvalid}, 32'd1);
    check_val("start_latency_busy", {31'd0, busy}, 32'd1);
    repeat (4) @(negedge clk);
    check_val("single_busy_low", {31'd0, busy}, 32'd0);
    check_val("single_q_empty", exp_q.size(), 0);
    check_val("single_count", {16'd0, pkt_count}, 32'd1);

    // Backpressure with a fixed TREADY pattern.
    @(posedge clk); #1;
    push_pkts(16'h0000, 3, 1, 0, 1'b0);
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_start(8'd3, 16'h0000, 1'b0, 8'd0);
    for (int k = 0; k < 6; k++) begin
      tready = pat[k];
      @(posedge clk); #1;
    end
    tready = 1'b1;
    wait_done("bp");
    check_val("bp_count", {16'd0, pkt_count}, 32'd2);

    // Repeat with gap=2, stopped while the third packet is sending.
    @(posedge clk); #1;
    push_pkts(16'h00A0, 2, 3, 2, 1'b1);
    do_start(8'd2, 16'h00A0, 1'b1, 8'd2);
    wait_data(16'h00A4, "rep_a4");
    i_stop = 1'b1;
    @(posedge clk); #1;
    i_stop = 1'b0;
    wait_done("rep");
    check_val("rep_count", {16'd0, pkt_count}, 32'd5);
    repeat (5) @(negedge clk);
    check_val("rep_idle_valid", {31'd0, tvalid}, 32'd0);

    // Back-to-back with data wrap-around, stopped in the second packet.
    @(posedge clk); #1;
    push_pkts(16'hFFFE, 3, 2, 0, 1'b1);
    do_start(8'd3, 16'hFFFE, 1'b1, 8'd0);
    wait_data(16'h0001, "b2b_0001");
    i_stop = 1'b1;
    @(posedge clk); #1;
    i_stop = 1'b0;
    wait_done("b2b");
    check_val("b2b_count", {16'd0, pkt_count}, 32'd7);

    // Zero length: the start is ignored.
    @(posedge clk); #1;
    do_start(8'd0, 16'h1234, 1'b0, 8'd0);
    repeat (3) @(negedge clk);
    check_val("zero_valid", {31'd0, tvalid}, 32'd0);
    check_val("zero_busy", {31'd0, busy}, 32'd0);

    // Start while busy: ignored, with no extra packet afterwards.
    @(posedge clk); #1;
    push_pkts(16'h0300, 5, 1, 0, 1'b1);
    do_start(8'd5, 16'h0300, 1'b0, 8'd0);
    do_start(8'd1, 16'h0055, 1'b0, 8'd0);
    wait_done("busy_start");
    repeat (6) @(negedge clk);
    check_val("busy_start_q", exp_q.size(), 0);
    check_val("busy_start_count", {16'd0, pkt_count}, 32'd8);
    check_val("busy_start_valid", {31'd0, tvalid}, 32'd0);

    // Reset on the third beat of a 6-beat packet.
    mon_en = 1'b0;
    @(posedge clk); #1;
    do_start(8'd6, 16'h0200, 1'b0, 8'd0);
    wait_data(16'h0202, "rst_mid");
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    @(negedge clk);
    check_val("rst_mid_valid", {31'd0, tvalid}, 32'd0);
    check_val("rst_mid_count", {16'd0, pkt_count}, 32'd0);
    check_val("rst_mid_busy", {31'd0, busy}, 32'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    push_pkts(16'h0010, 2, 1, 0, 1'b1);
    do_start(8'd2, 16'h0010, 1'b0, 8'd0);
    wait_done("post_rst");
    check_val("post_rst_count", {16'd0, pkt_count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
